// File: rtl/ddr5_ser_pkg.sv
// Shared types and constants for the DDR5 4:1 serializer sequencing controller.
package ddr5_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    // Preamble beat values, replicated across the beat width.
    localparam logic PRE_P0 = 1'b0;
    localparam logic PRE_P1 = 1'b1;
    localparam logic PRE_P2 = 1'b0;
    localparam logic PRE_P3 = 1'b1;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        case (ph)
            PH0:     return PH1;
            PH1:     return PH2;
            PH2:     return PH3;
            default: return PH0;
        endcase
    endfunction

endpackage

// File: rtl/ddr5_ser_fifo2.sv
// Two-entry synchronous FIFO; push is ignored when full, pop when empty.
module ddr5_ser_fifo2 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          push_c;
    logic          pop_c;

    assign push_c  = push_i && (count_q != 2'd2);
    assign pop_c   = pop_i && (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = 2'(count_q + 2'd1);
        end else if (pop_c && !push_c) begin
            count_d = 2'(count_q - 2'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_c) wr_ptr_q <= ~wr_ptr_q;
            if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_c) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ddr5_serializer_ctrl.sv
// Sequencing controller feeding one 4:1 DDR5 serializer from a 2-deep group FIFO.
// Optional DDR5_SER_PREAMBLE_EN inserts a one-window preamble before each burst from idle.
module ddr5_serializer_ctrl
    import ddr5_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [4*WIDTH-1:0] req_data_i,
    input  logic               req_last_i,
    output logic               ser_enable_o,
    output logic [1:0]         ser_phase_o,
    output logic [WIDTH-1:0]   ser_p0_o,
    output logic [WIDTH-1:0]   ser_p1_o,
    output logic [WIDTH-1:0]   ser_p2_o,
    output logic [WIDTH-1:0]   ser_p3_o,
    output logic               busy_o,
    output logic               underrun_o
);

    localparam int unsigned GW = 4 * WIDTH;
    localparam int unsigned EW = GW + 1;

    state_e           state_q;
    logic [1:0]       phase_q;
    logic             last_q;
    logic             enable_q;
    logic             busy_q;
    logic             underrun_q;
    logic [WIDTH-1:0] p0_q, p1_q, p2_q, p3_q;

    logic [EW-1:0]    head_c;
    logic             full_c;
    logic             empty_c;
    logic             pop_c;
    logic             load_pre_c;
    logic             go_idle_c;

    ddr5_ser_fifo2 #(.DW(EW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_valid_i),
        .data_i  ({req_last_i, req_data_i}),
        .pop_i   (pop_c),
        .data_o  (head_c),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

    assign req_ready_o  = !full_c;
    assign ser_enable_o = enable_q;
    assign ser_phase_o  = phase_q;
    assign ser_p0_o     = p0_q;
    assign ser_p1_o     = p1_q;
    assign ser_p2_o     = p2_q;
    assign ser_p3_o     = p3_q;
    assign busy_o       = busy_q;
    assign underrun_o   = underrun_q;

    // Window-boundary decisions: pop a group, start a preamble, or fall back to idle.
    always_comb begin
        pop_c      = 1'b0;
        load_pre_c = 1'b0;
        go_idle_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef DDR5_SER_PREAMBLE_EN
                load_pre_c = !empty_c;
`else
                pop_c      = !empty_c;
`endif
            end
`ifdef DDR5_SER_PREAMBLE_EN
            ST_PRE:  pop_c = (phase_q == PH3);
`endif
            ST_DATA: begin
                if (phase_q == PH3) begin
                    pop_c     = !empty_c;
                    go_idle_c = empty_c;
                end
            end
            default: go_idle_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH0;
            last_q     <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (go_idle_c) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH0;
            last_q   <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            if (state_q == ST_DATA && !last_q) underrun_q <= 1'b1;
        end else if (pop_c) begin
            state_q  <= ST_DATA;
            phase_q  <= PH0;
            last_q   <= head_c[GW];
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
        end else if (load_pre_c) begin
            state_q  <= ST_PRE;
            phase_q  <= PH0;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
        end else if (state_q != ST_IDLE) begin
            phase_q <= next_phase(phase_q);
        end
    end

    // Beat hold registers change only when a new window starts at phase 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || go_idle_c) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else if (pop_c) begin
            p0_q <= head_c[0*WIDTH +: WIDTH];
            p1_q <= head_c[1*WIDTH +: WIDTH];
            p2_q <= head_c[2*WIDTH +: WIDTH];
            p3_q <= head_c[3*WIDTH +: WIDTH];
        end else if (load_pre_c) begin
            p0_q <= {WIDTH{PRE_P0}};
            p1_q <= {WIDTH{PRE_P1}};
            p2_q <= {WIDTH{PRE_P2}};
            p3_q <= {WIDTH{PRE_P3}};
        end
    end

endmodule
